sprite_compositor: RTL and testbench

Downstream stage of the per-sprite hit detectors in the game video path. It takes the `active` flag and 12-bit shape address from each of `NUM_SPRITES` detectors and picks the highest-priority hit. It then fetches that sprite's pixel from the synchronous shape RAM and merges it over the background colour with a colour-key transparency test. It also keeps sticky per-sprite collision flags, which software reads over the register bus.

---
 rtl/sprite_compositor.sv | 141 ++++++++++++++
 tb/tb_sprite_compositor.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Sprite compositor: picks the highest-priority sprite hit, fetches its shape pixel
// and merges it over the background with colour-key transparency; tracks collisions.
module sprite_compositor #(
  parameter int          NUM_SPRITES     = 4,
  parameter logic [11:0] COLLISION_INDEX = 12'h010,
  parameter logic [11:0] KEY_INDEX       = 12'h011
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SPRITES-1:0]    sprite_active_i,
  input  logic [12*NUM_SPRITES-1:0] sprite_address_i,
  input  logic                      in_visible_i,
  input  logic [7:0]                background_color_i,
  output logic [11:0]               shape_addr_o,
  input  logic [7:0]                shape_data_i,
  input  logic                      register_write_i,
  input  logic                      register_read_i,
  input  logic [11:0]               register_index_i,
  input  logic [15:0]               register_write_value_i,
  output logic [15:0]               register_read_value_o,
  output logic [7:0]                pixel_color_o
);

  logic                   w_hit;
  logic [11:0]            w_win_addr;
  logic [3:0]             w_act_count;
  logic [NUM_SPRITES-1:0] w_coll_new;
  logic                   w_rd_coll;
  logic                   w_wr_key;
  logic [7:0]             w_pixel_next;
  logic                   w_unused_bits;

  logic                   r_s1_valid;
  logic                   r_s1_hit;
  logic                   r_s1_vis;
  logic [7:0]             r_s1_bg;
  logic [NUM_SPRITES-1:0] r_s1_active;
  logic [11:0]            r_s1_addr;

  logic                   r_s2_valid;
  logic                   r_s2_hit;
  logic                   r_s2_vis;
  logic [7:0]             r_s2_bg;

  logic [7:0]             r_pixel;
  logic [NUM_SPRITES-1:0] r_flags;
  logic [7:0]             r_key;
  logic [15:0]            r_read_value;

  assign w_unused_bits = &{1'b0, register_write_value_i[15:8]};

  // Scan from the top so the lowest-index active sprite is the last to assign.
  always_comb begin
    w_hit      = 1'b0;
    w_win_addr = 12'h000;
    for (int n = NUM_SPRITES - 1; n >= 0; n--) begin
      if (sprite_active_i[n]) begin
        w_hit      = 1'b1;
        w_win_addr = sprite_address_i[12*n +: 12];
      end
    end
  end

  always_comb begin
    w_act_count = 4'd0;
    for (int n = 0; n < NUM_SPRITES; n++) begin
      w_act_count = w_act_count + {3'b000, r_s1_active[n]};
    end
    w_coll_new = '0;
    if (r_s1_valid && r_s1_vis && (w_act_count >= 4'd2)) begin
      w_coll_new = r_s1_active;
    end
  end

  assign w_rd_coll = register_read_i && (register_index_i == COLLISION_INDEX);
  assign w_wr_key  = register_write_i && (register_index_i == KEY_INDEX);

  always_comb begin
    w_pixel_next = 8'h00;
    if (r_s2_valid && r_s2_vis) begin
      if (r_s2_hit && (shape_data_i != r_key)) begin
        w_pixel_next = shape_data_i;
      end else begin
        w_pixel_next = r_s2_bg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_hit    <= 1'b0;
      r_s1_vis    <= 1'b0;
      r_s1_bg     <= 8'h00;
      r_s1_active <= '0;
      r_s1_addr   <= 12'h000;
      r_s2_valid  <= 1'b0;
      r_s2_hit    <= 1'b0;
      r_s2_vis    <= 1'b0;
      r_s2_bg     <= 8'h00;
      r_pixel     <= 8'h00;
    end else begin
      r_s1_valid  <= 1'b1;
      r_s1_hit    <= w_hit;
      r_s1_vis    <= in_visible_i;
      r_s1_bg     <= background_color_i;
      r_s1_active <= sprite_active_i;
      // Address holds on a miss; the cleared hit flag masks the stale RAM data.
      if (w_hit) begin
        r_s1_addr <= w_win_addr;
      end
      r_s2_valid  <= r_s1_valid;
      r_s2_hit    <= r_s1_hit;
      r_s2_vis    <= r_s1_vis;
      r_s2_bg     <= r_s1_bg;
      r_pixel     <= w_pixel_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags      <= '0;
      r_key        <= 8'h00;
      r_read_value <= 16'h0000;
    end else begin
      if (register_read_i) begin
        r_read_value <= w_rd_coll ? {{(16-NUM_SPRITES){1'b0}}, r_flags} : 16'h0000;
      end
      // A collision landing on the clearing edge survives into the next read.
      r_flags <= (w_rd_coll ? '0 : r_flags) | w_coll_new;
      if (w_wr_key) begin
        r_key <= register_write_value_i[7:0];
      end
    end
  end

  assign shape_addr_o          = r_s1_addr;
  assign pixel_color_o         = r_pixel;
  assign register_read_value_o = r_read_value;

endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor: directed scenarios plus a randomized run
// checked against a per-pixel reference model with a synchronous RAM model.
module tb_sprite_compositor;
  localparam int          NS   = 4;
  localparam logic [11:0] COLL = 12'h010;
  localparam logic [11:0] KEYI = 12'h011;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NS-1:0]   sprite_active_i;
  logic [12*NS-1:0] sprite_address_i;
  logic            in_visible_i;
  logic [7:0]      background_color_i;
  logic [11:0]     shape_addr_o;
  logic [7:0]      shape_data_i = 8'h00;
  logic            register_write_i;
  logic            register_read_i;
  logic [11:0]     register_index_i;
  logic [15:0]     register_write_value_i;
  logic [15:0]     register_read_value_o;
  logic [7:0]      pixel_color_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] mem [0:4095];

  sprite_compositor #(.NUM_SPRITES(NS), .COLLISION_INDEX(COLL), .KEY_INDEX(KEYI)) dut (
    .clk(clk), .reset(reset),
    .sprite_active_i(sprite_active_i), .sprite_address_i(sprite_address_i),
    .in_visible_i(in_visible_i), .background_color_i(background_color_i),
    .shape_addr_o(shape_addr_o), .shape_data_i(shape_data_i),
    .register_write_i(register_write_i), .register_read_i(register_read_i),
    .register_index_i(register_index_i), .register_write_value_i(register_write_value_i),
    .register_read_value_o(register_read_value_o), .pixel_color_o(pixel_color_o)
  );

  always #5 clk = ~clk;

  // Synchronous shape RAM: data for the address seen at an edge appears after it.
  always @(posedge clk) shape_data_i <= mem[shape_addr_o];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sprite_active_i        = '0;
    sprite_address_i       = '0;
    in_visible_i           = 1'b1;
    background_color_i     = 8'h11;
    register_write_i       = 1'b0;
    register_read_i        = 1'b0;
    register_index_i       = 12'h000;
    register_write_value_i = 16'h0000;
  endtask

  task automatic set_sprite(input int n, input logic [11:0] a);
    sprite_active_i[n]           = 1'b1;
    sprite_address_i[12*n +: 12] = a;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 reset = 1'b1;
    #1;
    checks++; if (pixel_color_o !== 8'h00) begin failures++; $display("FAIL reset_pixel got=%h exp=00", pixel_color_o); end
    checks++; if (shape_addr_o !== 12'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", shape_addr_o); end
    checks++; if (register_read_value_o !== 16'h0000) begin failures++; $display("FAIL reset_rdval got=%h exp=0000", register_read_value_o); end
    @(negedge clk) reset = 1'b0;
    register_read_i = 1'b1; register_index_i = COLL;
    tick();
    register_read_i = 1'b0;
    checks++; if (register_read_value_o !== 16'h0000) begin failures++; $display("FAIL reset_flags got=%h exp=0000", register_read_value_o); end
  endtask

  task automatic test_single_sprite();
    idle_inputs();
    mem[12'h345] = 8'h5A;
    sprite_address_i = 48'hABC_DEF_000_123;
    set_sprite(2, 12'h345);
    tick();
    checks++; if (shape_addr_o !== 12'h345) begin failures++; $display("FAIL single_addr got=%h exp=345", shape_addr_o); end
    idle_inputs();
    tick(); tick();
    checks++; if (pixel_color_o !== 8'h5A) begin failures++; $display("FAIL single_pixel got=%h exp=5a", pixel_color_o); end
  endtask

  task automatic test_priority_transparency();
    idle_inputs();
    mem[12'h123] = 8'h00;
    mem[12'h456] = 8'h77;
    set_sprite(1, 12'h123);
    set_sprite(3, 12'h456);
    tick();
    checks++; if (shape_addr_o !== 12'h123) begin failures++; $display("FAIL prio_addr got=%h exp=123", shape_addr_o); end
    idle_inputs();
    tick(); tick();
    checks++; if (pixel_color_o !== 8'h11) begin failures++; $display("FAIL prio_pixel got=%h exp=11", pixel_color_o); end
  endtask

  task automatic test_color_key();
    idle_inputs();
    mem[12'h200] = 8'hE3;
    mem[12'h201] = 8'h00;
    register_write_i = 1'b1; register_index_i = KEYI; register_write_value_i = 16'hABE3;
    tick();
    idle_inputs();
    set_sprite(0, 12'h200);
    tick();
    idle_inputs();
    set_sprite(0, 12'h201);
    tick();
    idle_inputs();
    tick();
    checks++; if (pixel_color_o !== 8'h11) begin failures++; $display("FAIL key_match got=%h exp=11", pixel_color_o); end
    tick();
    checks++; if (pixel_color_o !== 8'h00) begin failures++; $display("FAIL key_nomatch got=%h exp=00", pixel_color_o); end
    // Writes to foreign indices must leave the key at E3.
    register_write_i = 1'b1; register_index_i = 12'h012; register_write_value_i = 16'h0000;
    tick();
    register_index_i = COLL;
    tick();
    idle_inputs();
    set_sprite(0, 12'h200);
    tick();
    idle_inputs();
    tick(); tick();
    checks++; if (pixel_color_o !== 8'h11) begin failures++; $display("FAIL key_ignored_wr got=%h exp=11", pixel_color_o); end
    register_write_i = 1'b1; register_index_i = KEYI; register_write_value_i = 16'h0000;
    tick();
    idle_inputs();
  endtask

  task automatic test_collision();
    idle_inputs();
    tick(); tick(); tick();
    register_read_i = 1'b1; register_index_i = COLL;
    tick();
    idle_inputs();
    set_sprite(0, 12'h010);
    set_sprite(2, 12'h020);
    tick();
    idle_inputs();
    tick(); tick();
    register_read_i = 1'b1; register_index_i = COLL;
    tick();
    checks++; if (register_read_value_o !== 16'h0005) begin failures++; $display("FAIL coll_first got=%h exp=0005", register_read_value_o); end
    tick();
    checks++; if (register_read_value_o !== 16'h0000) begin failures++; $display("FAIL coll_second got=%h exp=0000", register_read_value_o); end
    idle_inputs();
    sprite_active_i = 4'b0011;
    tick();
    sprite_active_i = 4'b1010;
    tick();
    sprite_active_i = 4'b0000;
    register_read_i = 1'b1; register_index_i = COLL;
    tick();
    checks++; if (register_read_value_o !== 16'h0003) begin failures++; $display("FAIL coll_coincident got=%h exp=0003", register_read_value_o); end
    tick();
    checks++; if (register_read_value_o !== 16'h000A) begin failures++; $display("FAIL coll_retained got=%h exp=000a", register_read_value_o); end
    register_read_i = 1'b0;
    tick();
    checks++; if (register_read_value_o !== 16'h000A) begin failures++; $display("FAIL rd_hold got=%h exp=000a", register_read_value_o); end
    register_read_i = 1'b1; register_index_i = 12'h012;
    tick();
    checks++; if (register_read_value_o !== 16'h0000) begin failures++; $display("FAIL rd_other got=%h exp=0000", register_read_value_o); end
    idle_inputs();
  endtask

  task automatic test_blanking();
    idle_inputs();
    register_read_i = 1'b1; register_index_i = COLL;
    tick();
    idle_inputs();
    in_visible_i = 1'b0; background_color_i = 8'h55;
    mem[12'h300] = 8'h99;
    set_sprite(0, 12'h300);
    set_sprite(1, 12'h301);
    tick();
    idle_inputs();
    tick(); tick();
    checks++; if (pixel_color_o !== 8'h00) begin failures++; $display("FAIL blank_pixel got=%h exp=00", pixel_color_o); end
    tick();
    register_read_i = 1'b1; register_index_i = COLL;
    tick();
    checks++; if (register_read_value_o !== 16'h0000) begin failures++; $display("FAIL blank_flags got=%h exp=0000", register_read_value_o); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    mem[12'h345] = 8'h5A;
    register_write_i = 1'b1; register_index_i = KEYI; register_write_value_i = 16'h005A;
    tick();
    idle_inputs();
    sprite_active_i = 4'b0011;
    tick();
    idle_inputs();
    tick();
    register_read_i = 1'b1; register_index_i = COLL;
    tick();
    idle_inputs();
    set_sprite(2, 12'h345);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (pixel_color_o !== 8'h00) begin failures++; $display("FAIL midrst_pixel got=%h exp=00", pixel_color_o); end
    checks++; if (shape_addr_o !== 12'h000) begin failures++; $display("FAIL midrst_addr got=%h exp=000", shape_addr_o); end
    checks++; if (register_read_value_o !== 16'h0000) begin failures++; $display("FAIL midrst_rdval got=%h exp=0000", register_read_value_o); end
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    checks++; if (pixel_color_o !== 8'h00) begin failures++; $display("FAIL flush_1 got=%h exp=00", pixel_color_o); end
    checks++; if (shape_addr_o !== 12'h345) begin failures++; $display("FAIL flush_addr got=%h exp=345", shape_addr_o); end
    tick();
    checks++; if (pixel_color_o !== 8'h00) begin failures++; $display("FAIL flush_2 got=%h exp=00", pixel_color_o); end
    tick();
    checks++; if (pixel_color_o !== 8'h5A) begin failures++; $display("FAIL post_rst_pixel got=%h exp=5a", pixel_color_o); end
    idle_inputs();
    register_read_i = 1'b1; register_index_i = COLL;
    tick();
    checks++; if (register_read_value_o !== 16'h0000) begin failures++; $display("FAIL post_rst_flags got=%h exp=0000", register_read_value_o); end
    idle_inputs();
  endtask

  task automatic test_random(input int n_cycles);
    logic        q_hit[$];
    logic        q_vis[$];
    logic [11:0] q_addr[$];
    logic [7:0]  q_bg[$];
    int          ce[$];
    logic [NS-1:0] cb[$];
    logic [7:0]  mkey, exp_pix, d, bg;
    logic [11:0] last_addr, waddr, ridx, widx, a;
    logic [15:0] last_rd, wval;
    logic [NS-1:0] act, acc;
    logic        hit, vis, rd, wr, h, v;
    int          e, r;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(0, 15));
    idle_inputs();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    mkey = 8'h00; last_addr = 12'h000; last_rd = 16'h0000; e = 0;
    for (int c = 0; c < n_cycles; c++) begin
      act = NS'($urandom_range(0, (1 << NS) - 1));
      if ($urandom_range(0, 1) == 0) act = act & NS'(1 << $urandom_range(0, NS - 1));
      vis = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 3) == 0);
      ridx = ($urandom_range(0, 9) < 7) ? COLL : 12'($urandom_range(0, 4095));
      wr = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 4);
      widx = (r < 2) ? KEYI : (r == 2) ? COLL : 12'($urandom_range(0, 4095));
      wval = {8'($urandom), 4'h0, 4'($urandom)};
      sprite_active_i        = act;
      in_visible_i           = vis;
      background_color_i     = 8'($urandom);
      sprite_address_i       = 48'({$urandom(), $urandom()});
      register_read_i        = rd;
      register_write_i       = wr;
      register_index_i       = rd ? ridx : widx;
      if (rd && wr) widx = ridx;
      register_write_value_i = wval;
      hit = 1'b0; waddr = 12'h000;
      for (int k = 0; k < NS; k++) begin
        if (act[k] && !hit) begin
          hit = 1'b1;
          waddr = sprite_address_i[12*k +: 12];
        end
      end
      q_hit.push_back(hit); q_vis.push_back(vis); q_addr.push_back(waddr); q_bg.push_back(background_color_i);
      tick();
      e++;
      if (hit) last_addr = waddr;
      checks++; if (shape_addr_o !== last_addr) begin failures++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, shape_addr_o, last_addr); end
      if (vis && ($countones(act) >= 2)) begin ce.push_back(e + 1); cb.push_back(act); end
      if (rd) begin
        if (ridx == COLL) begin
          acc = '0;
          for (int j = ce.size() - 1; j >= 0; j--) begin
            if (ce[j] < e) begin
              acc = acc | cb[j];
              ce.delete(j);
              cb.delete(j);
            end
          end
          last_rd = 16'(acc);
        end else begin
          last_rd = 16'h0000;
        end
      end
      checks++; if (register_read_value_o !== last_rd) begin failures++; $display("FAIL rand_rdval cyc=%0d got=%h exp=%h", c, register_read_value_o, last_rd); end
      if (q_hit.size() > 2) begin
        h = q_hit.pop_front(); v = q_vis.pop_front(); a = q_addr.pop_front(); bg = q_bg.pop_front();
        d = mem[a];
        exp_pix = !v ? 8'h00 : (h && (d != mkey)) ? d : bg;
        checks++; if (pixel_color_o !== exp_pix) begin failures++; $display("FAIL rand_pixel cyc=%0d got=%h exp=%h", c, pixel_color_o, exp_pix); end
      end
      if (wr && (widx == KEYI)) mkey = wval[7:0];
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_single_sprite();
    test_priority_transparency();
    test_color_key();
    test_collision();
    test_blanking();
    test_reset_mid();
    test_random(800);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
